// File: rtl/booth_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_multiplier_pkg
// Purpose  : Shared constants for the radix-2 Booth multiplier: FSM state
//            encoding and the default operand width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package booth_multiplier_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_S_IDLE   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_S_ADD    = 3'd1;
    localparam logic [c_STATE_W-1:0] c_S_SHIFT  = 3'd2;
    localparam logic [c_STATE_W-1:0] c_S_OUT_HI = 3'd3;
    localparam logic [c_STATE_W-1:0] c_S_OUT_LO = 3'd4;
    localparam logic [c_STATE_W-1:0] c_S_DONE   = 3'd5;

endpackage : booth_multiplier_pkg
`default_nettype wire

// File: rtl/booth_multiplier_addsub.sv
`default_nettype none
// ============================================================================
// Module   : booth_multiplier_addsub
// Purpose  : (WIDTH+1)-bit adder/subtractor for the Booth partial-product
//            accumulator. With i_sub=1 it forms i_a + ~i_m + 1 (i_a - i_m).
// Ports    : i_a      in  WIDTH+1  accumulator operand (A)
//            i_m      in  WIDTH+1  sign-extended multiplicand (M)
//            i_sub    in  1        1 = subtract, 0 = add
//            o_result out WIDTH+1  sum / difference (wraps modulo 2^(WIDTH+1))
// Revision : 1.0 - initial release
// ============================================================================
module booth_multiplier_addsub
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_m,
    input  logic           i_sub,
    output logic [WIDTH:0] o_result
);

    logic [WIDTH:0] w_m_sel;
    logic [WIDTH:0] w_carry_in;

    // Two's-complement subtract: invert M and inject the +1 as carry-in.
    assign w_m_sel    = i_sub ? ~i_m : i_m;
    assign w_carry_in = {{WIDTH{1'b0}}, i_sub};
    assign o_result   = i_a + w_m_sel + w_carry_in;

endmodule : booth_multiplier_addsub
`default_nettype wire

// File: rtl/booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : booth_multiplier
// Purpose  : Sequential signed radix-2 Booth multiplier, WIDTH x WIDTH ->
//            2*WIDTH product, delivered over obus in two beats (high half,
//            then low half), followed by a one-cycle stop strobe.
// Ports    : CLK    in  1      clock, rising edge
//            RESET  in  1      asynchronous active-high reset
//            bgn    in  1      start request, sampled only in IDLE
//            ibusa  in  WIDTH  signed multiplier Q, captured on the bgn edge
//            ibusb  in  WIDTH  signed multiplicand M, captured on the bgn edge
//            obus   out WIDTH  product beat (OUT_HI / OUT_LO), 0 otherwise
//            stop   out 1      done strobe, high only in DONE
//            ovf    out 1      only when MUL_OVF_EN is defined: high in DONE
//                              iff the product does not fit in WIDTH signed
// Config   : MUL_OVF_EN - adds the ovf output
// Revision : 1.0 - initial release
// ============================================================================
module booth_multiplier
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             bgn,
    input  logic [WIDTH-1:0] ibusa,
    input  logic [WIDTH-1:0] ibusb,
    output logic [WIDTH-1:0] obus,
    output logic             stop
`ifdef MUL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [c_STATE_W-1:0] r_state;
    logic [WIDTH:0]       r_a;      // one guard bit so -2^(W-1) squared is exact
    logic [WIDTH-1:0]     r_q;
    logic                 r_q_m1;
    logic [WIDTH:0]       r_m;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_sub;
    logic [WIDTH:0]       w_sum;

    // Booth pair 10 subtracts M; 01 adds it. Other pairs ignore w_sum.
    assign w_sub = r_q[0] & ~r_q_m1;

    booth_multiplier_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a      (r_a),
        .i_m      (r_m),
        .i_sub    (w_sub),
        .o_result (w_sum)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= c_S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_q_m1  <= 1'b0;
            r_m     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bgn) begin
                        r_a     <= '0;
                        r_q_m1  <= 1'b0;
                        r_cnt   <= '0;
                        r_q     <= ibusa;
                        r_m     <= {ibusb[WIDTH-1], ibusb};
                        r_state <= c_S_ADD;
                    end
                end
                c_S_ADD: begin
                    if (r_q[0] ^ r_q_m1) begin
                        r_a <= w_sum;
                    end
                    r_state <= c_S_SHIFT;
                end
                c_S_SHIFT: begin
                    // Arithmetic right shift of the {A, Q, q_m1} chain.
                    {r_a, r_q, r_q_m1} <= {r_a[WIDTH], r_a, r_q};
                    r_cnt              <= r_cnt + c_CNT_ONE;
                    r_state            <= (r_cnt == c_CNT_LAST) ? c_S_OUT_HI : c_S_ADD;
                end
                c_S_OUT_HI: r_state <= c_S_OUT_LO;
                c_S_OUT_LO: r_state <= c_S_DONE;
                c_S_DONE:   r_state <= c_S_IDLE;
                default:    r_state <= c_S_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no combinational path from inputs.
    always_comb begin
        obus = '0;
        stop = 1'b0;
        case (r_state)
            c_S_OUT_HI: obus = r_a[WIDTH-1:0];
            c_S_OUT_LO: obus = r_q;
            c_S_DONE:   stop = 1'b1;
            default: begin
                obus = '0;
                stop = 1'b0;
            end
        endcase
    end

`ifdef MUL_OVF_EN
    // Product fits in WIDTH signed bits only if the high half is pure sign
    // extension of the low half's MSB.
    assign ovf = (r_state == c_S_DONE) && (r_a[WIDTH-1:0] != {WIDTH{r_q[WIDTH-1]}});
`endif

endmodule : booth_multiplier
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_multiplier
// Purpose  : Directed self-checking bench for booth_multiplier (WIDTH=8).
// Config   : honours MUL_OVF_EN (connects and checks ovf when defined)
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier;
    import booth_multiplier_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       bgn;
    logic [7:0] ibusa;
    logic [7:0] ibusb;
    logic [7:0] obus;
    logic       stop;
`ifdef MUL_OVF_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    booth_multiplier #(
        .WIDTH (8)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bgn   (bgn),
        .ibusa (ibusa),
        .ibusb (ibusb),
        .obus  (obus),
        .stop  (stop)
`ifdef MUL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Present operands for one edge; afterwards the bench sits just after e0.
    task automatic start(input logic [7:0] a, input logic [7:0] b);
        bgn   = 1'b1;
        ibusa = a;
        ibusb = b;
        tick();
        bgn   = 1'b0;
        ibusa = 8'($urandom);
        ibusb = 8'($urandom);
    endtask

    // Called just after edge e0+k0; follows the op to the IDLE after DONE.
    task automatic finish_op(input string tag, input logic [15:0] exp_prod,
                             input logic exp_ovf, input int k0);
        for (int k = k0; k < 15; k++) begin
            check({tag, "_busy"}, {23'd0, stop, obus}, 32'd0);
            tick();
        end
        check({tag, "_busy_last"}, {23'd0, stop, obus}, 32'd0);
        tick();
        check({tag, "_hi"}, {23'd0, stop, obus}, {23'd0, 1'b0, exp_prod[15:8]});
`ifdef MUL_OVF_EN
        check({tag, "_ovf_hi"}, {31'd0, ovf}, 32'd0);
`endif
        tick();
        check({tag, "_lo"}, {23'd0, stop, obus}, {23'd0, 1'b0, exp_prod[7:0]});
        tick();
        check({tag, "_done"}, {23'd0, stop, obus}, {23'd0, 1'b1, 8'h00});
`ifdef MUL_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`endif
        tick();
        check({tag, "_idle_stop"}, {31'd0, stop}, 32'd0);
        check({tag, "_idle_state"}, {29'd0, dut.r_state}, {29'd0, c_S_IDLE});
    endtask

    initial begin
        RESET = 1'b1;
        bgn   = 1'b0;
        ibusa = 8'h00;
        ibusb = 8'h00;
        @(negedge CLK);
        check("reset_out", {23'd0, stop, obus}, 32'd0);
        check("reset_state", {29'd0, dut.r_state}, {29'd0, c_S_IDLE});
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        // Basic products, signs and boundaries
        start(8'd7, 8'd3);
        finish_op("t1_7x3", 16'h0015, 1'b0, 0);
        start(8'hFB, 8'h06);
        finish_op("t2_m5x6", 16'hFFE2, 1'b0, 0);
        start(8'h80, 8'h80);
        finish_op("t3_m128xm128", 16'h4000, 1'b1, 0);
        start(8'h00, 8'hFF);
        finish_op("t4_0xm1", 16'h0000, 1'b0, 0);
        start(8'h7F, 8'h80);
        finish_op("t4_127xm128", 16'hC080, 1'b1, 0);

        // Stray bgn mid-operation, then asynchronous reset mid-operation
        start(8'd7, 8'd3);
        repeat (4) tick();
        bgn   = 1'b1;
        ibusa = 8'h55;
        ibusb = 8'h11;
        tick();
        bgn   = 1'b0;
        check("t5_stray_state", {29'd0, dut.r_state}, {29'd0, c_S_SHIFT});
        check("t5_stray_cnt", {29'd0, dut.r_cnt}, 32'd2);
        tick();
        tick();
        #2;
        RESET = 1'b1;
        #1;
        check("t5_rst_out", {23'd0, stop, obus}, 32'd0);
        check("t5_rst_state", {29'd0, dut.r_state}, {29'd0, c_S_IDLE});
        check("t5_rst_regs", {dut.r_q, dut.r_a[7:0], 13'd0, dut.r_cnt}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        start(8'h7F, 8'hFF);
        finish_op("t5_127xm1", 16'hFF81, 1'b0, 0);

        // bgn held high: ignored in DONE, restarts in the first IDLE cycle
        bgn   = 1'b1;
        ibusa = 8'd5;
        ibusb = 8'd5;
        tick();
        ibusa = 8'd2;
        ibusb = 8'd3;
        finish_op("t6_first_5x5", 16'h0019, 1'b0, 0);
        tick();
        check("t6_restart_state", {29'd0, dut.r_state}, {29'd0, c_S_ADD});
        bgn   = 1'b0;
        ibusa = 8'($urandom);
        ibusb = 8'($urandom);
        finish_op("t6_second_2x3", 16'h0006, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_booth_multiplier
`default_nettype wire
